// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg
// Shared types and default parameter values for the stimulus sequencer.
//   state_e      : sequencer FSM states (IDLE, FETCH, DRIVE, DONE)
//   DEF_*        : default FIELD_W / N_FIELDS / DEPTH used by stim_sequencer
package stim_seq_pkg;

  localparam int DEF_FIELD_W  = 128;
  localparam int DEF_N_FIELDS = 2;
  localparam int DEF_DEPTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/stim_ram.sv
// stim_ram
// Program store for the stimulus sequencer: DEPTH x W synchronous RAM with
// one write port and one registered read port. On a same-address write/read
// in one cycle the read returns the previous contents (read-first).
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset (clears only the read register)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : read strobe; rd_data holds its value while low
//   rd_addr  : read address
//   rd_data  : registered read word
module stim_ram #(
  parameter int W     = 256,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM macros; only
  // the output register is reset, which is what the sequencer exposes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: non-blocking assignment here is what makes the read see the old
  // word when a write hits the same address in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer
// Stimulus replay engine. A program of W-bit words (W = FIELD_W*N_FIELDS) is
// written into stim_ram, then replayed from address 0 to last_addr under a
// valid/ready handshake, optionally looping. Each word is presented on
// out_fields, field i = out_fields[i*FIELD_W +: FIELD_W].
// Optional feature macro: STIM_SEQ_CHKSUM_EN -- when defined, chksum is the
// running XOR of every accepted vector; otherwise chksum is tied to zero.
// Ports:
//   clk, rst           : clock and synchronous active-low reset
//   wr_en/wr_addr/wr_data : program RAM write port (usable at any time)
//   start              : begin a run at address 0 (only accepted in IDLE)
//   last_addr, loop_en : run bounds, latched when start is accepted
//   abort              : end the current run (done pulses)
//   out_valid/out_ready: vector handshake
//   out_fields, pc     : current vector and its program address
//   busy, done, chksum : status outputs
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter  int FIELD_W  = DEF_FIELD_W,
  parameter  int N_FIELDS = DEF_N_FIELDS,
  parameter  int DEPTH    = DEF_DEPTH,
  localparam int W        = FIELD_W * N_FIELDS,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          start,
  input  logic [AW-1:0] last_addr,
  input  logic          loop_en,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_fields,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  chksum
);

  // Highest legal program address; last_addr values above it are clamped.
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] last_q;
  logic          loop_q;
  logic          out_valid_q;
  logic          start_ok;
  logic          hs;
  logic          rd_en;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    start_ok = 1'b0;
    rd_en    = 1'b0;
    hs       = out_valid_q && out_ready;
    unique case (state_q)
      IDLE: begin
        // abort beats a simultaneous start: the run never begins.
        if (start && !abort) begin
          start_ok = 1'b1;
          pc_d     = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          rd_en   = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hs) begin
          if (pc_q != last_q) begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end else if (loop_q) begin
            pc_d    = '0;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
        if (abort) begin
          pc_d    = pc_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      // A vector is on offer exactly while the FSM sits in DRIVE.
      out_valid_q <= (state_d == DRIVE);
      if (start_ok) begin
        last_q <= (last_addr > LAST_MAX) ? LAST_MAX : last_addr;
        loop_q <= loop_en;
      end
    end
  end

  // The RAM read register doubles as the out_fields register: it only loads
  // in FETCH, so the vector stays stable through DRIVE even if the program
  // is rewritten underneath it.
  stim_ram #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (pc_q),
    .rd_data (out_fields)
  );

`ifdef STIM_SEQ_CHKSUM_EN
  logic [W-1:0] chksum_q;

  // A handshake coinciding with abort is still an accepted vector.
  always_ff @(posedge clk) begin
    if (!rst)          chksum_q <= '0;
    else if (start_ok) chksum_q <= '0;
    else if (hs)       chksum_q <= chksum_q ^ out_fields;
  end

  assign chksum = chksum_q;
`else
  assign chksum = '0;
`endif

  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer
// Directed self-checking bench for stim_sequencer. Inputs are driven and
// outputs sampled 1 time unit after the rising edge.
module tb_stim_sequencer;

  localparam int FIELD_W  = 128;
  localparam int N_FIELDS = 2;
  localparam int DEPTH    = 16;
  localparam int W        = FIELD_W * N_FIELDS;
  localparam int AW       = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          loop_en = 1'b0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_fields;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic [W-1:0]  chksum;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stim_sequencer #(
    .FIELD_W  (FIELD_W),
    .N_FIELDS (N_FIELDS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .last_addr  (last_addr),
    .loop_en    (loop_en),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fields (out_fields),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .chksum     (chksum)
  );

  function automatic logic [W-1:0] mk_word(input logic [7:0] b);
    return {(W/8){b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns with the sequencer in FETCH.
  task automatic start_run(input logic [AW-1:0] la, input logic le);
    last_addr = la; loop_en = le; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    tests_run++;
    if ({out_valid, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: valid/busy/done=%b required 000", {out_valid, busy, done});
    end
    tests_run++;
    if (out_fields !== '0 || pc !== '0 || chksum !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: out_fields=%h pc=%0d chksum=%h required all zero",
               out_fields, pc, chksum);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_linear_run();
    logic [W-1:0] exp_w [3];
    exp_w[0] = mk_word(8'h11); exp_w[1] = mk_word(8'h22); exp_w[2] = mk_word(8'h33);
    for (int i = 0; i < 3; i++) write_word(AW'(i), exp_w[i]);
    out_ready = 1'b1;
    start_run(AW'(2), 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL linear_fetch: valid=%b busy=%b required 0 1", out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL linear_bubble%0d: valid=%b required 0", i, out_valid);
        end
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || pc !== AW'(i) || out_fields !== exp_w[i]) begin
        tests_failed++;
        $display("FAIL linear_vec%0d: valid=%b pc=%0d data=%h required 1 %0d %h",
                 i, out_valid, pc, out_fields, i, exp_w[i]);
      end
    end
    tests_run++;
    if (out_fields[FIELD_W +: FIELD_W] !== exp_w[2][FIELD_W +: FIELD_W]) begin
      tests_failed++;
      $display("FAIL linear_field1: got %h required %h",
               out_fields[FIELD_W +: FIELD_W], exp_w[2][FIELD_W +: FIELD_W]);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL linear_done: done=%b valid=%b busy=%b required 1 0 1", done, out_valid, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL linear_idle: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    start_run(AW'(2), 1'b0);
    tick();          // pc 0 on offer, accepted at next edge
    tick();          // FETCH for pc 1
    out_ready = 1'b0;
    tick();          // pc 1 on offer, stalled
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (out_valid !== 1'b1 || pc !== AW'(1) || out_fields !== mk_word(8'h22)) begin
        tests_failed++;
        $display("FAIL stall_cyc%0d: valid=%b pc=%0d data=%h required 1 1 %h",
                 c, out_valid, pc, out_fields, mk_word(8'h22));
      end
      if (c < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b required 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || pc !== AW'(2) || out_fields !== mk_word(8'h33)) begin
      tests_failed++;
      $display("FAIL stall_next: valid=%b pc=%0d data=%h required 1 2 %h",
               out_valid, pc, out_fields, mk_word(8'h33));
    end
    tick();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_loop_abort();
    logic [W-1:0] exp_w [2];
    exp_w[0] = mk_word(8'hA1); exp_w[1] = mk_word(8'hB2);
    write_word(AW'(0), exp_w[0]);
    write_word(AW'(1), exp_w[1]);
    out_ready = 1'b1;
    start_run(AW'(1), 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || pc !== AW'(i % 2) || out_fields !== exp_w[i % 2]) begin
        tests_failed++;
        $display("FAIL loop_vec%0d: valid=%b pc=%0d data=%h required 1 %0d %h",
                 i, out_valid, pc, out_fields, i % 2, exp_w[i % 2]);
      end
    end
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL loop_abort: done=%b valid=%b required 1 0", done, out_valid);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL loop_abort_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_chksum();
    logic [W-1:0] a, b, exp_sum;
    a = {(W/16){16'hF0F0}};
    b = {(W/16){16'h0FF0}};
`ifdef STIM_SEQ_CHKSUM_EN
    exp_sum = a ^ b;
`else
    exp_sum = '0;
`endif
    write_word(AW'(0), a);
    write_word(AW'(1), b);
    out_ready = 1'b1;
    start_run(AW'(1), 1'b0);
    tick(); tick(); tick(); tick();   // A, FETCH, B, DONE
    tests_run++;
    if (done !== 1'b1 || chksum !== exp_sum) begin
      tests_failed++;
      $display("FAIL chksum_run: done=%b chksum=%h required 1 %h", done, chksum, exp_sum);
    end
    tick();
    start_run(AW'(1), 1'b0);
    tests_run++;
    if (chksum !== '0) begin
      tests_failed++;
      $display("FAIL chksum_clear: chksum=%h required 0", chksum);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    // start and abort together in IDLE: nothing happens
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_abort_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    write_word(AW'(0), mk_word(8'h11));
    write_word(AW'(1), mk_word(8'h22));
    write_word(AW'(2), mk_word(8'h33));
    out_ready = 1'b0;
    start_run(AW'(2), 1'b0);
    tick();
    start = 1'b1; last_addr = AW'(0);
    tick();
    start = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || pc !== AW'(0) || out_fields !== mk_word(8'h11)) begin
      tests_failed++;
      $display("FAIL start_in_drive: valid=%b busy=%b pc=%0d data=%h required 1 1 0 %h",
               out_valid, busy, pc, out_fields, mk_word(8'h11));
    end
    out_ready = 1'b1;
    tick(); tick();
    tests_run++;
    if (out_valid !== 1'b1 || pc !== AW'(1) || out_fields !== mk_word(8'h22)) begin
      tests_failed++;
      $display("FAIL start_ignored_next: valid=%b pc=%0d data=%h required 1 1 %h",
               out_valid, pc, out_fields, mk_word(8'h22));
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, busy, done} !== 3'b000 || out_fields !== '0 || pc !== '0 || chksum !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: valid/busy/done=%b data=%h pc=%0d chksum=%h required 000 0 0 0",
               {out_valid, busy, done}, out_fields, pc, chksum);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_first();
    write_word(AW'(0), mk_word(8'h5A));
    out_ready = 1'b1;
    start_run(AW'(0), 1'b0);
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = mk_word(8'hC3);
    tick();
    wr_en = 1'b0;
    tests_run++;
    if (out_fields !== mk_word(8'h5A)) begin
      tests_failed++;
      $display("FAIL read_first_old: data=%h required %h", out_fields, mk_word(8'h5A));
    end
    tick(); tick();
    start_run(AW'(0), 1'b0);
    tick();
    tests_run++;
    if (out_fields !== mk_word(8'hC3)) begin
      tests_failed++;
      $display("FAIL read_first_new: data=%h required %h", out_fields, mk_word(8'hC3));
    end
    tick(); tick();
  endtask

  task automatic test_full_depth();
    for (int k = 0; k < DEPTH; k++) write_word(AW'(k), mk_word(8'(8'h40 + k)));
    out_ready = 1'b1;
    start_run(AW'(DEPTH - 1), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) tick();
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || pc !== AW'(i) || out_fields !== mk_word(8'(8'h40 + i))) begin
        tests_failed++;
        $display("FAIL depth_vec%0d: valid=%b pc=%0d data=%h required 1 %0d %h",
                 i, out_valid, pc, out_fields, i, mk_word(8'(8'h40 + i)));
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL depth_done: done=%b valid=%b required 1 0", done, out_valid);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL depth_idle: busy=%b required 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_linear_run();
    test_backpressure();
    test_loop_abort();
    test_chksum();
    test_start_ignored_and_reset();
    test_read_first();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
